// File: rtl/frogger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frogger_pkg
// Description : Shared types and playfield constants for the frogger blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package frogger_pkg;

    typedef logic [8:0] coord_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        COOL    = 2'd2
    } mover_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int PF_X_MAX = 310;
    localparam int PF_Y_MAX = 230;

    // Fixed key priority: up > down > left > right.
    function automatic dir_t sel_dir(input logic up, input logic down, input logic left);
        if (up)
            return DIR_UP;
        else if (down)
            return DIR_DOWN;
        else if (left)
            return DIR_LEFT;
        else
            return DIR_RIGHT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frog_position_ctrl_adder.sv
`default_nettype none
// ============================================================================
// Module      : stride_adder9
// Description : 9-bit unsigned adder with carry out, used for coordinate steps.
// Revision    : 1.0 - initial release
// ============================================================================
module stride_adder9 (
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic [8:0] s,
    output logic       c
);

    assign {c, s} = {1'b0, a} + {1'b0, b};

endmodule
`default_nettype wire

// File: rtl/frog_position_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frog_position_ctrl
// Description : Frog coordinate register, one clamped step per key press.
// Revision    : 1.0 - initial release
// ============================================================================
module frog_position_ctrl
    import frogger_pkg::*;
#(
    parameter int STEP     = 10,
    parameter int X_MAX    = PF_X_MAX,
    parameter int Y_MAX    = PF_Y_MAX,
    parameter int X_START  = 150,
    parameter int Y_START  = 230,
    parameter int COOLDOWN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       hit,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       moved,
    output logic       busy
);

    localparam int     c_cnt_w    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam coord_t c_step     = coord_t'(STEP);
    localparam coord_t c_step_neg = ~c_step + coord_t'(1);
    localparam coord_t c_x_max    = coord_t'(X_MAX);
    localparam coord_t c_y_max    = coord_t'(Y_MAX);
    localparam coord_t c_x_start  = coord_t'(X_START);
    localparam coord_t c_y_start  = coord_t'(Y_START);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(COOLDOWN - 1);

    mover_state_t        r_state, w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
    coord_t              r_x, r_y;
    logic                r_moved;

    logic   w_any, w_is_y, w_is_dec, w_take, w_c;
    dir_t   w_dir;
    coord_t w_a, w_b, w_s, w_max, w_cand;

    assign w_any = up | down | left | right;

    // One adder shared by both axes; the direction picks operand and stride sign.
    always_comb begin
        w_dir    = sel_dir(up, down, left);
        w_is_y   = (w_dir == DIR_UP) || (w_dir == DIR_DOWN);
        w_is_dec = (w_dir == DIR_UP) || (w_dir == DIR_LEFT);
        w_a      = w_is_y ? r_y : r_x;
        w_b      = w_is_dec ? c_step_neg : c_step;
        w_max    = w_is_y ? c_y_max : c_x_max;
    end

    stride_adder9 u_adder (
        .a (w_a),
        .b (w_b),
        .s (w_s),
        .c (w_c)
    );

    always_comb begin
        if (w_is_dec)
            w_cand = (w_a < c_step) ? '0 : w_s;
        else
            w_cand = (w_c || (w_s > w_max)) ? w_max : w_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (hit) begin
            w_state_nxt = w_any ? RELEASE : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any)
                        w_state_nxt = RELEASE;
                end
                RELEASE: begin
                    if (!w_any) begin
                        w_state_nxt = COOL;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end
                COOL: begin
                    if (w_any)
                        w_state_nxt = RELEASE;
                    else if (r_cnt == '0)
                        w_state_nxt = IDLE;
                    else
                        w_cnt_nxt = r_cnt - 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (r_state != IDLE);
        w_take = (r_state == IDLE) && w_any && !hit;
    end

    always_ff @(posedge clk) begin
        if (reset || hit) begin
            r_x     <= c_x_start;
            r_y     <= c_y_start;
            r_moved <= 1'b0;
        end else begin
            r_moved <= w_take;
            if (w_take) begin
                if (w_is_y)
                    r_y <= w_cand;
                else
                    r_x <= w_cand;
            end
        end
    end

    assign x     = r_x;
    assign y     = r_y;
    assign moved = r_moved;

endmodule
`default_nettype wire

// File: tb/tb_frog_position_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frog_position_ctrl
// Description : Directed and random checks of frog_position_ctrl vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frog_position_ctrl;

    localparam int STEP     = 10;
    localparam int X_MAX    = 310;
    localparam int Y_MAX    = 230;
    localparam int X_START  = 150;
    localparam int Y_START  = 230;
    localparam int COOLDOWN = 4;

    localparam logic [3:0] K_NONE  = 4'b0000;
    localparam logic [3:0] K_UP    = 4'b1000;
    localparam logic [3:0] K_DOWN  = 4'b0100;
    localparam logic [3:0] K_LEFT  = 4'b0010;
    localparam logic [3:0] K_RIGHT = 4'b0001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, hit = 1'b0;
    logic [8:0] x, y;
    logic       moved, busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model: position, "ready for a new press", and quiet-edge run length.
    int m_x, m_y, m_quiet;
    bit m_moved, m_ready;

    frog_position_ctrl #(
        .STEP(STEP), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
        .X_START(X_START), .Y_START(Y_START), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk), .reset(reset), .up(up), .down(down), .left(left),
        .right(right), .hit(hit), .x(x), .y(y), .moved(moved), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [3:0] k, input logic h, input logic rs);
        bit any;
        any = (k != 4'b0000);
        if (rs) begin
            m_x = X_START; m_y = Y_START; m_moved = 0; m_ready = 1; m_quiet = 0;
        end else if (h) begin
            m_x = X_START; m_y = Y_START; m_moved = 0; m_ready = !any; m_quiet = 0;
        end else if (m_ready && any) begin
            if (k[3])      m_y = (m_y < STEP) ? 0 : m_y - STEP;
            else if (k[2]) m_y = (m_y + STEP > Y_MAX) ? Y_MAX : m_y + STEP;
            else if (k[1]) m_x = (m_x < STEP) ? 0 : m_x - STEP;
            else           m_x = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
            m_moved = 1; m_ready = 0; m_quiet = 0;
        end else begin
            m_moved = 0;
            if (!m_ready) begin
                if (any) begin
                    m_quiet = 0;
                end else begin
                    m_quiet++;
                    if (m_quiet == COOLDOWN + 1) m_ready = 1;
                end
            end
        end
    endtask

    task automatic tick(input logic [3:0] k, input logic h, input logic rs);
        {up, down, left, right} = k;
        hit   = h;
        reset = rs;
        @(posedge clk);
        model_edge(k, h, rs);
        #1;
        if (moved === 1'b1) pulses++;
        check("x", 32'(x), 32'(m_x));
        check("y", 32'(y), 32'(m_y));
        check("moved", 32'(moved), 32'(m_moved));
        check("busy", 32'(busy), 32'(!m_ready));
    endtask

    task automatic press(input logic [3:0] k);
        tick(k, 1'b0, 1'b0);
        repeat (COOLDOWN + 1) tick(K_NONE, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick(K_NONE, 1'b0, 1'b1);
        tick(K_NONE, 1'b0, 1'b1);
    endtask

    initial begin
        logic [3:0] k;

        // Reset state
        do_reset();
        check("reset_x", 32'(x), 150);
        check("reset_y", 32'(y), 230);
        check("reset_busy", 32'(busy), 0);
        check("reset_moved", 32'(moved), 0);

        // Single right tap, then cooldown timing
        pulses = 0;
        tick(K_RIGHT, 1'b0, 1'b0);
        repeat (COOLDOWN) tick(K_NONE, 1'b0, 1'b0);
        check("busy_before_idle", 32'(busy), 1);
        tick(K_NONE, 1'b0, 1'b0);
        check("busy_after_idle", 32'(busy), 0);
        tick(K_NONE, 1'b0, 1'b0);
        check("tap_x", 32'(x), 160);
        check("tap_y", 32'(y), 230);
        check("tap_pulses", 32'(pulses), 1);

        // Held key moves only once
        do_reset();
        pulses = 0;
        repeat (20) tick(K_RIGHT, 1'b0, 1'b0);
        repeat (COOLDOWN + 1) tick(K_NONE, 1'b0, 1'b0);
        check("hold_x", 32'(x), 160);
        check("hold_pulses", 32'(pulses), 1);

        // Bottom clamp still pulses moved
        pulses = 0;
        press(K_DOWN);
        check("down_clamp_y", 32'(y), 230);
        check("down_clamp_pulse", 32'(pulses), 1);

        // Walk to top row and clamp at zero
        repeat (24) press(K_UP);
        check("top_y", 32'(y), 0);
        pulses = 0;
        press(K_UP);
        check("top_clamp_y", 32'(y), 0);
        check("top_clamp_pulse", 32'(pulses), 1);

        // Left edge clamp and right edge clamp
        repeat (16) press(K_LEFT);
        check("left_edge_x", 32'(x), 0);
        repeat (32) press(K_RIGHT);
        check("right_edge_x", 32'(x), 310);

        // Simultaneous up+left: only up moves
        do_reset();
        tick(K_UP | K_LEFT, 1'b0, 1'b0);
        check("combo_y", 32'(y), 220);
        check("combo_x", 32'(x), 150);
        tick(K_LEFT, 1'b0, 1'b0);
        check("combo_absorbed_x", 32'(x), 150);
        repeat (COOLDOWN + 1) tick(K_NONE, 1'b0, 1'b0);

        // Hit during cooldown
        do_reset();
        tick(K_RIGHT, 1'b0, 1'b0);
        repeat (2) tick(K_NONE, 1'b0, 1'b0);
        check("pre_hit_x", 32'(x), 160);
        tick(K_NONE, 1'b1, 1'b0);
        check("hit_x", 32'(x), 150);
        check("hit_moved", 32'(moved), 0);
        check("hit_busy", 32'(busy), 0);

        // Press inside cooldown window is not a move
        tick(K_RIGHT, 1'b0, 1'b0);
        repeat (2) tick(K_NONE, 1'b0, 1'b0);
        tick(K_RIGHT, 1'b0, 1'b0);
        check("cool_press_x", 32'(x), 160);
        check("cool_press_moved", 32'(moved), 0);
        check("cool_press_busy", 32'(busy), 1);
        repeat (COOLDOWN + 1) tick(K_NONE, 1'b0, 1'b0);

        // Hit with a key held discards the key
        tick(K_DOWN, 1'b1, 1'b0);
        check("hit_key_busy", 32'(busy), 1);
        check("hit_key_moved", 32'(moved), 0);
        repeat (COOLDOWN + 1) tick(K_NONE, 1'b0, 1'b0);

        // Reset in RELEASE with key held
        do_reset();
        tick(K_RIGHT, 1'b0, 1'b0);
        tick(K_RIGHT, 1'b0, 1'b0);
        tick(K_RIGHT, 1'b0, 1'b1);
        check("rst_mid_x", 32'(x), 150);
        check("rst_mid_busy", 32'(busy), 0);
        tick(K_RIGHT, 1'b0, 1'b0);
        check("rst_then_x", 32'(x), 160);
        check("rst_then_moved", 32'(moved), 1);
        repeat (COOLDOWN + 1) tick(K_NONE, 1'b0, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            k[3] = ($urandom_range(0, 5) == 0);
            k[2] = ($urandom_range(0, 5) == 0);
            k[1] = ($urandom_range(0, 5) == 0);
            k[0] = ($urandom_range(0, 5) == 0);
            tick(k, $urandom_range(0, 59) == 0, $urandom_range(0, 299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frog_position_ctrl.md
Name: frog_position_ctrl

Overview:
- Holds the frog's 9-bit screen coordinates and steps them by a fixed pixel stride, one step per key press.
- Sits downstream of the player-input synchronisers and upstream of the renderer and collision checker.
- Instantiates the team's 9-bit stride adder (operands a/b, sum s, carry c) to form candidate coordinates, then clamps them to the playfield.
- Enforces one move per press, followed by a post-release cooldown.

Parameters:
- STEP, 10, pixel stride per move (must be < 512)
- X_MAX, 310, largest legal x (inclusive)
- Y_MAX, 230, largest legal y (inclusive); also start row
- X_START, 150, x after reset or hit
- Y_START, 230, y after reset or hit
- COOLDOWN, 4, clock cycles after release before a new press is accepted (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- up  in  1  level, already synchronised key (decrease y)
- down  in  1  level, increase y
- left  in  1  level, decrease x
- right  in  1  level, increase x
- hit  in  1  one-cycle collision pulse; returns frog to start
- x  out  9  current x coordinate (registered)
- y  out  9  current y coordinate (registered)
- moved  out  1  one-cycle pulse, high the cycle after x or y changes due to a key
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset, sampled only on the rising edge of clk.
- Reset values:
  - x=X_START, y=Y_START
  - moved=0, busy=0
  - state=IDLE, cooldown counter=0
- States: IDLE, RELEASE, COOL.
- IDLE, any key high at edge k:
  - Select direction by priority up > down > left > right.
  - At edge k the selected coordinate takes its clamped candidate value.
  - moved=1 for the cycle after edge k, then 0.
  - State goes to RELEASE.
- Candidate arithmetic, all unsigned 9-bit:
  - down/right: s = coord + STEP. If carry is set or s > MAX, result = MAX; else result = s.
  - up/left: if coord < STEP, result = 0; else result = coord − STEP (adder fed with the two's complement of STEP).
- moved pulses even when clamping leaves the coordinate unchanged: a move attempt was consumed.
- RELEASE: stays while any key is high. When all keys are low at an edge, load the counter with COOLDOWN−1 and go to COOL.
- COOL:
  - Decrement the counter each edge.
  - Any key high returns to RELEASE with the counter unchanged.
  - Counter == 0 with no key high goes to IDLE.
- hit: highest priority after reset, in any state.
  - At that edge: x=X_START, y=Y_START, moved=0.
  - Then go to RELEASE if any key is high, else IDLE.
  - A key press in the same cycle as hit is discarded.
- Simultaneous keys: only the highest-priority direction moves. The others are absorbed by RELEASE.
- busy = (state != IDLE), combinational from the state register.
- Reset mid-move or mid-cooldown returns everything to reset values at that edge. No pending move survives.

Decomposition:
- Shared package frogger_pkg holds:
  - typedef coord_t (logic [8:0])
  - enum mover_state_t {IDLE, RELEASE, COOL}
  - enum dir_t {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}
  - playfield constants PF_X_MAX=310, PF_Y_MAX=230
- Sub-module: one natural child, the existing 9-bit stride adder, instantiated once and shared between x and y through an input mux selected by dir_t. Clamp logic stays in this block.

Test Plan:
- Reset, then right held 1 cycle, released, idle 6 cycles -> x=160, y=230, moved high exactly one cycle, busy returns low 5 cycles after release.
- Right held 20 cycles -> x changes once only (150→160), exactly one moved pulse.
- From y=230 press down -> y stays 230, moved pulses (clamp). Press up 24 times with releases -> y=0, then a further up leaves y=0.
- Start at x=5 (press left from 15) -> x=0. Up+left together at reset position -> y=220, x=150 unchanged.
- hit asserted while in COOL with x=160 -> next cycle x=150, y=230, state IDLE, no moved pulse. Press during the cooldown window re-enters RELEASE and produces no move.
- Reset asserted in RELEASE with key still high -> next edge x=150, y=230, busy=0, then one move when the key is seen high in IDLE.
